// File: rtl/huffman_arbiter_if.sv
// Bundle between the two pixel requesters, the arbiter and the shared huffman core.
// slave = arbiter side, master = requesters/core side.
interface huffman_arbiter_if;
  logic       req0, req1, gnt0, gnt1, owner;
  logic       src_valid0, src_valid1, src_ready0, src_ready1;
  logic [7:0] src_data0, src_data1;
  logic       core_rst, gray_valid, code_valid;
  logic [7:0] gray_data;
  logic       done0, done1, err;

  modport slave (
    input  req0, req1, src_valid0, src_valid1, src_data0, src_data1, code_valid,
    output gnt0, gnt1, owner, src_ready0, src_ready1, core_rst, gray_valid, gray_data,
           done0, done1, err
  );

  modport master (
    output req0, req1, src_valid0, src_valid1, src_data0, src_data1, code_valid,
    input  gnt0, gnt1, owner, src_ready0, src_ready1, core_rst, gray_valid, gray_data,
           done0, done1, err
  );
endinterface

// File: rtl/huffman_arbiter.sv
// Round-robin frame arbiter sharing one huffman core between two pixel sources.
// Optional WAIT_CODE watchdog enabled by defining HUFF_ARB_TIMEOUT_EN.
module huffman_arbiter #(
  parameter int FRAME_LEN = 100,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             reset,
  huffman_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CORE_RST, STREAM, WAIT_CODE, DONE} state_t;

  localparam logic [7:0] FL = 8'(FRAME_LEN);

  if (FRAME_LEN < 1 || FRAME_LEN > 255 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_range
    $error("huffman_arbiter: FRAME_LEN/TIMEOUT out of range 1..255");
  end

  state_t     state, state_nxt;
  logic [1:0] gnt, gnt_nxt, done, done_nxt, ready;
  logic       owner, owner_nxt, last, last_nxt;
  logic       core_rst, core_rst_nxt, gray_valid, gray_valid_nxt;
  logic [7:0] gray_data, gray_data_nxt, pix_cnt, pix_cnt_nxt, src_data;
  logic       hs, winner;

`ifdef HUFF_ARB_TIMEOUT_EN
  localparam logic [7:0] TO = 8'(TIMEOUT);
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       err, err_nxt;
`endif

  // src_ready stays low once the frame is full, so pix_cnt cannot wrap
  assign ready[0] = (state == STREAM) && !owner && (pix_cnt < FL);
  assign ready[1] = (state == STREAM) &&  owner && (pix_cnt < FL);
  assign hs       = owner ? (bus.src_valid1 && ready[1]) : (bus.src_valid0 && ready[0]);
  assign src_data = owner ? bus.src_data1 : bus.src_data0;
  assign winner   = (bus.req0 && bus.req1) ? ~last : bus.req1;

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    owner_nxt      = owner;
    last_nxt       = last;
    core_rst_nxt   = 1'b0;
    gray_valid_nxt = 1'b0;
    gray_data_nxt  = gray_data;
    done_nxt       = 2'b00;
    pix_cnt_nxt    = pix_cnt;
`ifdef HUFF_ARB_TIMEOUT_EN
    err_nxt        = 1'b0;
    wait_cnt_nxt   = wait_cnt;
`endif
    case (state)
      IDLE: if (bus.req0 || bus.req1) begin
        gnt_nxt      = winner ? 2'b10 : 2'b01;
        owner_nxt    = winner;
        core_rst_nxt = 1'b1;
        pix_cnt_nxt  = 8'd0;
        state_nxt    = CORE_RST;
      end
      CORE_RST: state_nxt = STREAM;
      STREAM: if (hs) begin
        gray_valid_nxt = 1'b1;
        gray_data_nxt  = src_data;
        pix_cnt_nxt    = pix_cnt + 8'd1;
        if (pix_cnt == FL - 8'd1) begin
          state_nxt = WAIT_CODE;
`ifdef HUFF_ARB_TIMEOUT_EN
          wait_cnt_nxt = 8'd0;
`endif
        end
      end
      WAIT_CODE: begin
        if (bus.code_valid) begin
          done_nxt[owner] = 1'b1;
          state_nxt       = DONE;
        end
`ifdef HUFF_ARB_TIMEOUT_EN
        // code_valid on the limit cycle takes priority over the watchdog
        else if (wait_cnt == TO - 8'd1) begin
          err_nxt   = 1'b1;
          gnt_nxt   = 2'b00;
          last_nxt  = owner;
          state_nxt = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
`endif
      end
      DONE: begin
        gnt_nxt   = 2'b00;
        last_nxt  = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      owner      <= 1'b0;
      last       <= 1'b1;
      core_rst   <= 1'b0;
      gray_valid <= 1'b0;
      gray_data  <= 8'd0;
      done       <= 2'b00;
      pix_cnt    <= 8'd0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      owner      <= owner_nxt;
      last       <= last_nxt;
      core_rst   <= core_rst_nxt;
      gray_valid <= gray_valid_nxt;
      gray_data  <= gray_data_nxt;
      done       <= done_nxt;
      pix_cnt    <= pix_cnt_nxt;
    end
  end

`ifdef HUFF_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
      err      <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      err      <= err_nxt;
    end
  end
  assign bus.err = err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.gnt0       = gnt[0];
  assign bus.gnt1       = gnt[1];
  assign bus.owner      = owner;
  assign bus.src_ready0 = ready[0];
  assign bus.src_ready1 = ready[1];
  assign bus.core_rst   = core_rst;
  assign bus.gray_valid = gray_valid;
  assign bus.gray_data  = gray_data;
  assign bus.done0      = done[0];
  assign bus.done1      = done[1];
endmodule

// File: tb/tb_huffman_arbiter.sv
// Bench for huffman_arbiter: directed frames, scoreboard queues checked by a negedge monitor.
module tb_huffman_arbiter;
  localparam int FL = 100;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  huffman_arbiter_if bus();
  huffman_arbiter #(.FRAME_LEN(FL), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, err_exp = 0;
  logic [7:0] pix_q[$];
  logic [1:0] evt_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name, input int act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d expected=none t=%0t", name, act, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rdy(input bit n);
    return n ? int'(bus.src_ready1) : int'(bus.src_ready0);
  endfunction

  task automatic drv(input bit n, input logic v, input logic [7:0] d);
    if (n) begin
      bus.src_valid1 = v; bus.src_data1 = d; bus.src_valid0 = 1'b1; bus.src_data0 = 8'hA5;
    end else begin
      bus.src_valid0 = v; bus.src_data0 = d; bus.src_valid1 = 1'b1; bus.src_data1 = 8'hA5;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.gray_valid === 1'b1) begin
        if (pix_q.size() == 0) bad("pix_extra", int'(bus.gray_data));
        else chk("pix_data", int'(bus.gray_data), int'(pix_q.pop_front()));
      end
      if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
        if (evt_q.size() == 0) bad("done_extra", int'({bus.done1, bus.done0}));
        else chk("done_who", int'({bus.done1, bus.done0}), int'(evt_q.pop_front()));
      end
      if (bus.err === 1'b1) begin
        if (err_exp == 0) bad("err_extra", 1);
        else begin checks++; err_exp--; end
      end
    end
  endtask

  // Entered just after an edge with req already set; returns just after edge j+1
  // (code_dly<0) or after edge m+1 with the frame completed.
  task automatic frame(input bit n, input bit keep, input bit stall, input bit stray,
                       input int code_dly, input int seed);
    int acc, t;
    logic v;
    logic [7:0] d;
    tick();
    chk("gnt_own", n ? int'(bus.gnt1) : int'(bus.gnt0), 1);
    chk("gnt_other", n ? int'(bus.gnt0) : int'(bus.gnt1), 0);
    chk("owner", int'(bus.owner), int'(n));
    chk("core_rst_hi", int'(bus.core_rst), 1);
    chk("ready_in_core_rst", rdy(n), 0);
    if (!keep) begin
      if (n) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    end
    tick();
    chk("core_rst_lo", int'(bus.core_rst), 0);
    acc = 0;
    t = 0;
    while (acc < FL && t < 1000) begin
      chk("ready_own", rdy(n), 1);
      chk("ready_other", rdy(!n), 0);
      v = stall ? (t % 2 == 0) : 1'b1;
      d = 8'(seed + acc * 3);
      drv(n, v, d);
      bus.code_valid = stray && (t == 20);
      if (v) pix_q.push_back(d);
      tick();
      chk("gray_valid_lag", int'(bus.gray_valid), int'(v));
      if (v) acc++;
      t++;
    end
    bus.code_valid = 1'b0;
    chk("stream_len", acc, FL);
    // offer a 101st pixel; it must be refused
    drv(n, 1'b1, 8'hEE);
    chk("ready_full", rdy(n), 0);
    tick();
    chk("gray_valid_end", int'(bus.gray_valid), 0);
    bus.src_valid0 = 1'b0;
    bus.src_valid1 = 1'b0;
    if (code_dly >= 2) begin
      repeat (code_dly - 2) tick();
      bus.code_valid = 1'b1;
      evt_q.push_back(n ? 2'b10 : 2'b01);
      tick();
      bus.code_valid = 1'b0;
      chk("done_hi", n ? int'(bus.done1) : int'(bus.done0), 1);
      chk("gnt_hold_done", n ? int'(bus.gnt1) : int'(bus.gnt0), 1);
      tick();
      chk("done_lo", int'({bus.done1, bus.done0}), 0);
      chk("gnt_drop", int'({bus.gnt1, bus.gnt0}), 0);
    end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.code_valid = 1'b0;
    bus.src_valid0 = 1'b0; bus.src_valid1 = 1'b0;
    bus.src_data0 = 8'd0; bus.src_data1 = 8'd0;
    fork monitor(); join_none
    #2;
    chk("rst_gnt", int'({bus.gnt1, bus.gnt0}), 0);
    chk("rst_owner", int'(bus.owner), 0);
    chk("rst_core_rst", int'(bus.core_rst), 0);
    chk("rst_gray_valid", int'(bus.gray_valid), 0);
    chk("rst_gray_data", int'(bus.gray_data), 0);
    chk("rst_done", int'({bus.done1, bus.done0}), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_ready", int'({bus.src_ready1, bus.src_ready0}), 0);
    #11 reset = 1'b0;
    repeat (2) tick();
    chk("idle_gnt", int'({bus.gnt1, bus.gnt0}), 0);

    // single requester, back-to-back pixels, code 14 cycles after stream end
    bus.req0 = 1'b1;
    frame(1'b0, 1'b0, 1'b0, 1'b0, 14, 1);

    // fresh reset, then a standing tie: 0, 1, 0
    reset = 1'b1; #2 reset = 1'b0;
    chk("rst2_owner", int'(bus.owner), 0);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    frame(1'b0, 1'b1, 1'b0, 1'b0, 14, 40);
    frame(1'b1, 1'b1, 1'b1, 1'b0, 14, 90);
    frame(1'b0, 1'b1, 1'b0, 1'b1, 14, 7);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    chk("tie_idle", int'({bus.gnt1, bus.gnt0}), 0);

    // reset mid-frame at pixel 50
    bus.req0 = 1'b1;
    tick();
    chk("mid_gnt0", int'(bus.gnt0), 1);
    bus.req0 = 1'b0;
    tick();
    for (int i = 0; i < 50; i++) begin
      drv(1'b0, 1'b1, 8'(200 + i));
      pix_q.push_back(8'(200 + i));
      tick();
    end
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_gnt", int'({bus.gnt1, bus.gnt0}), 0);
    chk("arst_gray_valid", int'(bus.gray_valid), 0);
    chk("arst_core_rst", int'(bus.core_rst), 0);
    chk("arst_done", int'({bus.done1, bus.done0}), 0);
    chk("arst_ready", int'({bus.src_ready1, bus.src_ready0}), 0);
    chk("arst_pix_pending", pix_q.size(), 0);
    pix_q.delete();
    bus.src_valid0 = 1'b0; bus.src_valid1 = 1'b0;
    reset = 1'b0;
    bus.req1 = 1'b1;
    frame(1'b1, 1'b0, 1'b0, 1'b0, 5, 33);

    // frame with no code_valid
    bus.req0 = 1'b1;
    frame(1'b0, 1'b0, 1'b0, 1'b0, -1, 77);
`ifdef HUFF_ARB_TIMEOUT_EN
    for (int i = 0; i < TO - 2; i++) begin
      chk("err_early", int'(bus.err), 0);
      tick();
    end
    chk("err_early_last", int'(bus.err), 0);
    err_exp++;
    tick();
    chk("err_hi", int'(bus.err), 1);
    chk("err_gnt_drop", int'({bus.gnt1, bus.gnt0}), 0);
    chk("err_no_done", int'({bus.done1, bus.done0}), 0);
    bus.req1 = 1'b1;
    tick();
    chk("err_lo", int'(bus.err), 0);
    chk("regrant_after_err", int'(bus.gnt1), 1);
    bus.req1 = 1'b0;
`else
    for (int i = 0; i < 100; i++) begin
      chk("err_zero", int'(bus.err), 0);
      tick();
    end
    chk("wait_gnt_held", int'(bus.gnt0), 1);
    chk("wait_no_done", int'({bus.done1, bus.done0}), 0);
`endif
    reset = 1'b1; #2 reset = 1'b0;
    repeat (3) tick();
    chk("pix_q_empty", pix_q.size(), 0);
    chk("evt_q_empty", evt_q.size(), 0);
    chk("err_exp_zero", err_exp, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
